// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Handshaked, multi-cycle data RAM for the core's load/store unit. Accepts one
//   request at a time, waits WAIT_CYCLES extra cycles, performs the access with
//   RV32I byte/half/word lane handling, then holds the response until taken.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   i_req_valid / o_req_ready     request handshake
//   i_req_write                   1 = store, 0 = load
//   i_req_addr                    byte address
//   i_req_funct3                  RV32I funct3 (size and sign)
//   i_req_wdata                   store data, lane 0 aligned
//   o_rsp_valid / i_rsp_ready     response handshake
//   o_rsp_rdata                   formatted load data (0 for stores and errors)
//   o_rsp_error                   misaligned, out-of-range or illegal funct3
module data_mem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error
);

  localparam int          IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDXW-1:0] idx;
  logic            err;
  logic            access;
  logic [31:0]     word;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     ld_data;
  logic [3:0]      be;
  logic [31:0]     wline;

  assign idx    = addr_q[2 +: IDXW];
  // Access happens on the edge where the wait counter is already exhausted;
  // a reset on that same edge cancels the store.
  assign access = (state == WAIT) && (cnt == '0) && !reset;

  always_comb begin
    err = 1'b0;
    if (wr_q) begin
      if (f3_q > 3'd2) err = 1'b1;
    end else if (f3_q == 3'd3 || f3_q == 3'd6 || f3_q == 3'd7) begin
      err = 1'b1;
    end
    if (f3_q[1:0] == 2'd1 && addr_q[0]) err = 1'b1;
    if (f3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0) err = 1'b1;
    if (addr_q[31:2] >= DEPTH_L) err = 1'b1;
  end

  always_comb begin
    word    = mem[idx];
    lane_b  = word[{addr_q[1:0], 3'b000} +: 8];
    lane_h  = word[{addr_q[1], 4'b0000} +: 16];
    ld_data = '0;
    if (!err && !wr_q) begin
      case (f3_q)
        3'd0:    ld_data = {{24{lane_b[7]}}, lane_b};
        3'd1:    ld_data = {{16{lane_h[15]}}, lane_h};
        3'd2:    ld_data = word;
        3'd4:    ld_data = {24'd0, lane_b};
        3'd5:    ld_data = {16'd0, lane_h};
        default: ld_data = '0;
      endcase
    end
  end

  always_comb begin
    be    = 4'b1111;
    wline = wdata_q;
    case (f3_q[1:0])
      2'd0: begin
        be    = 4'b0001 << addr_q[1:0];
        wline = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wline = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wline = wdata_q;
      end
    endcase
  end

  // RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (access && wr_q && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wline[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            wr_q    <= i_req_write;
            addr_q  <= i_req_addr;
            f3_q    <= i_req_funct3;
            wdata_q <= i_req_wdata;
            cnt     <= WAIT_L;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= ld_data;
            err_q       <= err;
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state == IDLE) && !reset;
  assign o_rsp_valid = rsp_valid_q && !reset;
  assign o_rsp_rdata = reset ? '0 : rdata_q;
  assign o_rsp_error = err_q && !reset;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;

  // dut: WAIT_CYCLES=2, dut0: WAIT_CYCLES=0
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        req_valid0 = 1'b0, rsp_ready0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_error0;
  logic [31:0] rsp_rdata0;

  int sel = 0;
  logic        cur_ready, cur_valid, cur_error;
  logic [31:0] cur_rdata;
  assign cur_ready = (sel != 0) ? req_ready0 : req_ready;
  assign cur_valid = (sel != 0) ? rsp_valid0 : rsp_valid;
  assign cur_error = (sel != 0) ? rsp_error0 : rsp_error;
  assign cur_rdata = (sel != 0) ? rsp_rdata0 : rsp_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid0), .o_req_ready(req_ready0),
    .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
    .o_rsp_rdata(rsp_rdata0), .o_rsp_error(rsp_error0)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
    int          hold;
  } vec_t;

  typedef struct packed {
    logic        e;
    logic [31:0] r;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel != 0) req_valid0 = v; else req_valid = v;
  endtask

  task automatic set_rsp_ready(input logic v);
    if (sel != 0) rsp_ready0 = v; else rsp_ready = v;
  endtask

  // One full transaction; expected result pushed when driven, popped at response.
  task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] d, input logic [31:0] er, input logic ee,
                     input int hold, input int exp_lat);
    int   n;
    int   lat;
    exp_t e;
    sb.push_back('{e: ee, r: er});
    @(posedge clk); #1;
    req_write = w; req_addr = a; req_funct3 = f; req_wdata = d;
    set_valid(1'b1);
    n = 0;
    while (!cur_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({nm, ":req_ready"}, 32'(cur_ready), 32'd1);
    @(posedge clk); #1;
    set_valid(1'b0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cur_valid && lat < 40);
    chk({nm, ":latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      chk({nm, ":hold_valid"}, 32'(cur_valid), 32'd1);
      chk({nm, ":hold_rdata"}, cur_rdata, er);
      chk({nm, ":hold_req_ready"}, 32'(cur_ready), 32'd0);
      @(posedge clk); #1;
    end
    if (sb.size() == 0) begin
      chk({nm, ":scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, ":rdata"}, cur_rdata, e.r);
      chk({nm, ":error"}, 32'(cur_error), 32'(e.e));
    end
    set_rsp_ready(1'b1);
    @(posedge clk); #1;
    set_rsp_ready(1'b0);
    chk({nm, ":valid_cleared"}, 32'(cur_valid), 32'd0);
    chk({nm, ":ready_after"}, 32'(cur_ready), 32'd1);
  endtask

  initial begin
    int bad;
    // {write, addr, funct3, wdata, exp rdata, exp error, rsp_ready hold cycles}
    tv.push_back('{1'b1, 32'h08, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 0});
    tv.push_back('{1'b0, 32'h08, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, 5});
    tv.push_back('{1'b1, 32'h09, 3'd0, 32'h000000AA, 32'h0,        1'b0, 0});
    tv.push_back('{1'b0, 32'h08, 3'd2, 32'h0,        32'hDEADAAEF, 1'b0, 0});
    tv.push_back('{1'b0, 32'h09, 3'd0, 32'h0,        32'hFFFFFFAA, 1'b0, 0});
    tv.push_back('{1'b0, 32'h09, 3'd4, 32'h0,        32'h000000AA, 1'b0, 0});
    tv.push_back('{1'b0, 32'h0A, 3'd1, 32'h0,        32'hFFFFDEAD, 1'b0, 0});
    tv.push_back('{1'b0, 32'h0A, 3'd5, 32'h0,        32'h0000DEAD, 1'b0, 0});
    tv.push_back('{1'b0, 32'h06, 3'd2, 32'h0,        32'h0,        1'b1, 0});
    tv.push_back('{1'b1, 32'h0B, 3'd1, 32'h00001234, 32'h0,        1'b1, 0});
    tv.push_back('{1'b0, 32'h08, 3'd2, 32'h0,        32'hDEADAAEF, 1'b0, 0});
    tv.push_back('{1'b0, 32'h80, 3'd2, 32'h0,        32'h0,        1'b1, 0});
    tv.push_back('{1'b0, 32'h08, 3'd3, 32'h0,        32'h0,        1'b1, 0});
    tv.push_back('{1'b1, 32'h08, 3'd3, 32'h11111111, 32'h0,        1'b1, 0});
    tv.push_back('{1'b0, 32'h08, 3'd2, 32'h0,        32'hDEADAAEF, 1'b0, 0});
    tv.push_back('{1'b1, 32'h0C, 3'd2, 32'h11223344, 32'h0,        1'b0, 0});
    tv.push_back('{1'b1, 32'h0E, 3'd1, 32'h0000BEEF, 32'h0,        1'b0, 0});
    tv.push_back('{1'b0, 32'h0C, 3'd2, 32'h0,        32'hBEEF3344, 1'b0, 0});
    tv.push_back('{1'b1, 32'h0F, 3'd0, 32'h00000077, 32'h0,        1'b0, 0});
    tv.push_back('{1'b0, 32'h0C, 3'd2, 32'h0,        32'h77EF3344, 1'b0, 0});
    tv.push_back('{1'b0, 32'h0C, 3'd0, 32'h0,        32'h00000044, 1'b0, 0});
    tv.push_back('{1'b0, 32'h0C, 3'd1, 32'h0,        32'h00003344, 1'b0, 0});
    tv.push_back('{1'b0, 32'h0F, 3'd0, 32'h0,        32'h00000077, 1'b0, 0});
    tv.push_back('{1'b1, 32'h7C, 3'd2, 32'h0BADF00D, 32'h0,        1'b0, 0});
    tv.push_back('{1'b0, 32'h7C, 3'd2, 32'h0,        32'h0BADF00D, 1'b0, 0});
    tv.push_back('{1'b1, 32'h10, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:rsp_error", 32'(rsp_error), 32'd0);
    chk("rst:req_ready0", 32'(req_ready0), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst:idle_ready", 32'(req_ready), 32'd1);

    sel = 0;
    foreach (tv[i]) begin
      txn($sformatf("vec%0d", i), tv[i].w, tv[i].a, tv[i].f, tv[i].d,
          tv[i].er, tv[i].ee, tv[i].hold, 3);
    end

    // Reset while an SW 0x10 is in WAIT: no response, no commit
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'd2; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst:req_ready", 32'(req_ready), 32'd0);
    chk("midrst:rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) bad++;
      @(posedge clk); #1;
    end
    chk("midrst:no_response", 32'(bad), 32'd0);
    chk("midrst:ready", 32'(req_ready), 32'd1);
    txn("midrst:lw10", 1'b0, 32'h10, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 0, 3);

    // Zero wait-state build
    sel = 1;
    txn("w0:sw04", 1'b1, 32'h04, 3'd2, 32'hA5A5C3C3, 32'h0, 1'b0, 0, 1);
    txn("w0:lw04", 1'b0, 32'h04, 3'd2, 32'h0, 32'hA5A5C3C3, 1'b0, 2, 1);
    txn("w0:lh06", 1'b0, 32'h06, 3'd1, 32'h0, 32'hFFFFA5A5, 1'b0, 0, 1);
    txn("w0:lw05", 1'b0, 32'h05, 3'd2, 32'h0, 32'h0, 1'b1, 0, 1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
